// File: rtl/texture_stream_loader.sv
// Texture upload front end: header decode, payload forwarding, mode commit.
// Optional TEXTURE_LOADER_BYTESWAP_EN swaps the bytes of each 16-bit texel lane.
module texture_stream_loader #(
  parameter int STREAM_WIDTH = 16,
  parameter int SIZE         = 14
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [STREAM_WIDTH-1:0] s_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [STREAM_WIDTH-1:0] m_axis_tdata,
  output logic [3:0]              mode,
  output logic                    busy,
  output logic                    errMode,
  output logic                    errShort,
  output logic                    errLong
);

  localparam int LOGB = $clog2(STREAM_WIDTH / 8);
  localparam int CW   = SIZE - LOGB + 1;

  // Beat counts for 2 KiB, 8 KiB and 32 KiB textures
  localparam logic OK0 = (SIZE >= 11);
  localparam logic OK1 = (SIZE >= 13);
  localparam logic OK2 = (SIZE >= 15);
  localparam logic [CW-1:0] B0 = OK0 ? CW'(1) << (11 - LOGB) : '0;
  localparam logic [CW-1:0] B1 = OK1 ? CW'(1) << (13 - LOGB) : '0;
  localparam logic [CW-1:0] B2 = OK2 ? CW'(1) << (15 - LOGB) : '0;

  typedef enum logic [1:0] {HEADER, LOAD, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           beats_q, beats_d;
  logic [3:0]              pend_q, pend_d;
  logic [3:0]              mode_q, mode_d;
  logic                    vld_q, vld_d;
  logic                    last_q, last_d;
  logic [STREAM_WIDTH-1:0] data_q, data_d;
  logic                    em_q, em_d;
  logic                    es_q, es_d;
  logic                    el_q, el_d;

  logic                    rdy;
  logic                    hs_in;
  logic                    hdr_ok;
  logic [CW-1:0]           hdr_beats;
  logic [3:0]              hdr;
  logic [STREAM_WIDTH-1:0] pay;

`ifdef TEXTURE_LOADER_BYTESWAP_EN
  localparam int LANES = STREAM_WIDTH / 16;
  always_comb begin
    pay = '0;
    for (int i = 0; i < LANES; i++) begin
      pay[16*i +: 16] = {s_axis_tdata[16*i +: 8],
                         s_axis_tdata[16*i+8 +: 8]};
    end
  end
`else
  assign pay = s_axis_tdata;
`endif

  assign hdr = s_axis_tdata[3:0];

  always_comb begin
    hdr_ok    = 1'b0;
    hdr_beats = '0;
    case (hdr)
      4'b0001: begin hdr_ok = OK0; hdr_beats = B0; end
      4'b0010: begin hdr_ok = OK1; hdr_beats = B1; end
      4'b0100: begin hdr_ok = OK2; hdr_beats = B2; end
      default: ;
    endcase
  end

  // A header waits until the previous packet's last beat has left
  always_comb begin
    rdy = 1'b0;
    unique case (state_q)
      HEADER:  rdy = !vld_q;
      LOAD:    rdy = !vld_q || m_axis_tready;
      DRAIN:   rdy = 1'b1;
      default: rdy = 1'b0;
    endcase
  end

  assign s_axis_tready = resetn && rdy;
  assign hs_in         = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    pend_d  = pend_q;
    mode_d  = mode_q;
    vld_d   = vld_q;
    last_d  = last_q;
    data_d  = data_q;
    em_d    = em_q;
    es_d    = es_q;
    el_d    = el_q;
    if (vld_q && m_axis_tready) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
    end
    unique case (state_q)
      HEADER: if (hs_in) begin
        em_d = 1'b0;
        es_d = 1'b0;
        el_d = 1'b0;
        if (hdr_ok) begin
          pend_d  = hdr;
          beats_d = hdr_beats;
          state_d = LOAD;
        end else begin
          em_d    = 1'b1;
          state_d = s_axis_tlast ? HEADER : DRAIN;
        end
      end
      LOAD: if (hs_in) begin
        vld_d   = 1'b1;
        data_d  = pay;
        last_d  = 1'b0;
        beats_d = beats_q - CW'(1);
        if (beats_q == CW'(1)) begin
          last_d = 1'b1;
          mode_d = pend_q;
          if (s_axis_tlast) begin
            state_d = HEADER;
          end else begin
            el_d    = 1'b1;
            state_d = DRAIN;
          end
        end else if (s_axis_tlast) begin
          last_d  = 1'b1;
          es_d    = 1'b1;
          state_d = HEADER;
        end
      end
      DRAIN: if (hs_in && s_axis_tlast) begin
        state_d = HEADER;
      end
      default: state_d = HEADER;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= HEADER;
      beats_q <= '0;
      pend_q  <= '0;
      mode_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      em_q    <= 1'b0;
      es_q    <= 1'b0;
      el_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      data_q  <= data_d;
      em_q    <= em_d;
      es_q    <= es_d;
      el_q    <= el_d;
    end
  end

  assign m_axis_tvalid = vld_q;
  assign m_axis_tlast  = last_q;
  assign m_axis_tdata  = data_q;
  assign mode          = mode_q;
  assign busy          = (state_q != HEADER) || vld_q;
  assign errMode       = em_q;
  assign errShort      = es_q;
  assign errLong       = el_q;

endmodule

// File: tb/tb_texture_stream_loader.sv
// Randomized directed bench for texture_stream_loader.
// Reference model derives payload size and errors from the texture mode.
module tb_texture_stream_loader;

  localparam int SW   = 16;
  localparam int SZ   = 14;

  logic          clk = 1'b0;
  logic          resetn;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [SW-1:0] s_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [SW-1:0] m_axis_tdata;
  logic [3:0]    mode;
  logic          busy;
  logic          errMode;
  logic          errShort;
  logic          errLong;

  texture_stream_loader #(.STREAM_WIDTH(SW), .SIZE(SZ)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .mode          (mode),
    .busy          (busy),
    .errMode       (errMode),
    .errShort      (errShort),
    .errLong       (errLong)
  );

  always #5 clk = ~clk;

  int          checks    = 0;
  int          errors    = 0;
  int          timeouts  = 0;
  int          stall_err = 0;
  int          rdy_pct   = 100;
  logic [3:0]  cur_mode  = 4'b0000;
  logic [16:0] outq[$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data  = '0;

  // Sink: random ready, capture handshakes, watch hold-while-stalled
  always @(negedge clk) begin
    m_axis_tready = ($urandom_range(0, 99) < rdy_pct);
    #1;
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(m_axis_tvalid && m_axis_tdata == prev_data))
        stall_err++;
      if (m_axis_tvalid && m_axis_tready)
        outq.push_back({m_axis_tlast, m_axis_tdata});
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_pay(input logic [15:0] d);
`ifdef TEXTURE_LOADER_BYTESWAP_EN
    return {d[7:0], d[15:8]};
`else
    return d;
`endif
  endfunction

  task automatic send_beat(input logic [15:0] d, input logic l);
    int t;
    if ($urandom_range(0, 3) == 0) begin
      @(negedge clk);
      s_axis_tvalid = 1'b0;
    end
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    t = 0;
    forever begin
      #2;
      if (s_axis_tready) begin
        @(posedge clk);
        break;
      end
      t++;
      if (t > 2000) begin
        timeouts++;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      #3;
      t++;
    end while (busy && t < 5000);
    if (busy) timeouts++;
  endtask

  task automatic run_pkt(input string nm, input logic [3:0] hdr,
                         input int n, input int pct,
                         input logic [15:0] first);
    logic [15:0] pay[$];
    int   k, bytes, nb, cnt, mism, nlast, lidx;
    bit   ok;
    logic [3:0] exp_mode;
    rdy_pct   = pct;
    stall_err = 0;
    timeouts  = 0;
    outq.delete();
    for (int i = 0; i < n; i++)
      pay.push_back(i == 0 ? first : 16'($urandom));
    send_beat({12'($urandom), hdr}, n == 0);
    for (int i = 0; i < n; i++)
      send_beat(pay[i], i == n - 1);
    wait_idle();

    ok = 1'b0;
    nb = 0;
    k  = -1;
    if (hdr == 4'b0001) k = 0;
    if (hdr == 4'b0010) k = 1;
    if (hdr == 4'b0100) k = 2;
    if (k >= 0) begin
      bytes = 2048 << (2 * k);
      if (bytes <= (1 << SZ)) begin
        ok = 1'b1;
        nb = bytes * 8 / SW;
      end
    end
    cnt      = ok ? (n < nb ? n : nb) : 0;
    exp_mode = (ok && n >= nb) ? hdr : cur_mode;

    mism  = 0;
    nlast = 0;
    lidx  = -1;
    foreach (outq[i]) begin
      if (i < cnt && outq[i][15:0] !== exp_pay(pay[i])) mism++;
      if (outq[i][16]) begin
        nlast++;
        lidx = i;
      end
    end
    chk({nm, "/timeout"}, timeouts, 0);
    chk({nm, "/beats"}, outq.size(), cnt);
    chk({nm, "/data"}, mism, 0);
    chk({nm, "/tlast_cnt"}, nlast, (cnt > 0) ? 1 : 0);
    if (cnt > 0) chk({nm, "/tlast_pos"}, lidx, cnt - 1);
    chk({nm, "/mode"}, mode, exp_mode);
    chk({nm, "/errMode"}, errMode, !ok);
    chk({nm, "/errShort"}, errShort, ok && n < nb);
    chk({nm, "/errLong"}, errLong, ok && n > nb);
    chk({nm, "/hold"}, stall_err, 0);
    chk({nm, "/busy"}, busy, 1'b0);
    cur_mode = exp_mode;
  endtask

  initial begin
    int nl;
    resetn        = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst/tready", s_axis_tready, 1'b0);
    chk("rst/tvalid", m_axis_tvalid, 1'b0);
    chk("rst/mode", mode, 4'b0000);
    chk("rst/busy", busy, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    #3;
    chk("rel/tready", s_axis_tready, 1'b1);

    run_pkt("m32", 4'b0001, 1024, 100, 16'($urandom));
    run_pkt("m64_bp", 4'b0010, 4096, 50, 16'($urandom));
    run_pkt("m128_bad", 4'b0100, 100, 80, 16'($urandom));
    run_pkt("short", 4'b0001, 10, 60, 16'($urandom));
    run_pkt("long", 4'b0001, 1030, 90, 16'($urandom));
    run_pkt("hdr_only", 4'b0011, 0, 100, 16'h0);
    run_pkt("bad_1000", 4'b1000, 5, 100, 16'h0);

    // Reset in the middle of a 64x64 upload
    rdy_pct = 100;
    outq.delete();
    send_beat(16'h0002, 1'b0);
    for (int i = 0; i < 499; i++)
      send_beat(16'($urandom), 1'b0);
    @(negedge clk);
    resetn        = 1'b0;
    s_axis_tvalid = 1'b0;
    #3;
    chk("mid_rst/tvalid", m_axis_tvalid, 1'b0);
    chk("mid_rst/tlast", m_axis_tlast, 1'b0);
    chk("mid_rst/tdata", m_axis_tdata, 16'h0);
    chk("mid_rst/mode", mode, 4'b0000);
    chk("mid_rst/busy", busy, 1'b0);
    chk("mid_rst/errs", {errMode, errShort, errLong}, 3'b000);
    chk("mid_rst/tready", s_axis_tready, 1'b0);
    nl = 0;
    foreach (outq[i]) if (outq[i][16]) nl++;
    chk("mid_rst/no_tlast", nl, 0);
    @(negedge clk);
    resetn   = 1'b1;
    cur_mode = 4'b0000;

    run_pkt("after_rst", 4'b0001, 1024, 70, 16'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/texture_stream_loader.md
# texture_stream_loader

Upload front end that sits directly upstream of the texture buffer. It receives a texture-upload packet from the command stream: one header beat carrying the texture mode, followed by texel payload. It forwards exactly the payload size implied by the mode to the buffer's write stream and asserts `m_axis_tlast` on the final beat. It commits the new mode to the sampler side only once the upload is complete, and flags malformed packets.

## Interface
Parameters:
- `STREAM_WIDTH`, 16: width of input and output stream; multiple of 16 (one texel = 16 bit RGBA4444).
- `SIZE`, 14: texture buffer size in bytes, as power of two.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset; asynchronous, active-low.
- `s_axis_tvalid`  in  1  upload stream valid.
- `s_axis_tready`  out  1  upload stream ready.
- `s_axis_tlast`  in  1  last beat of upload packet.
- `s_axis_tdata`  in  STREAM_WIDTH  header or payload.
- `m_axis_tvalid`  out  1  to texture buffer.
- `m_axis_tready`  in  1  from texture buffer.
- `m_axis_tlast`  out  1  final payload beat.
- `m_axis_tdata`  out  STREAM_WIDTH  payload.
- `mode`  out  4  committed texture mode (one-hot: 0001 32x32, 0010 64x64, 0100 128x128).
- `busy`  out  1  a packet is in progress.
- `errMode`, `errShort`, `errLong`  out  1 each  sticky error flags.

## Operation
- States: HEADER, LOAD, DRAIN.
- HEADER:
  - `s_axis_tready`=1.
  - On an accepted beat, decode `s_axis_tdata[3:0]`, then clear all error flags.
  - Valid mode: one-hot and byte size ≤ 2^SIZE. Byte size = 2048 << (2·k) for k=0,1,2.
  - Valid mode: latch it as pending, load `beatsLeft` = bytes·8/STREAM_WIDTH, go to LOAD.
  - Invalid mode: set `errMode` and go to DRAIN. If the header carries `s_axis_tlast`, set `errMode` and stay in HEADER.
- LOAD:
  - Each accepted beat is forwarded into the output register and decrements `beatsLeft`.
  - The beat with `beatsLeft`==1 carries `m_axis_tlast`=1. On that beat, `mode`←pending on the same edge.
  - If `s_axis_tlast` also arrived on that beat, go to HEADER. Otherwise set `errLong` and go to DRAIN.
  - `s_axis_tlast` with `beatsLeft`>1: forward that beat with `m_axis_tlast`=1 (resets the buffer write address), set `errShort`, leave `mode` unchanged, go to HEADER.
- DRAIN:
  - `s_axis_tready`=1. Beats are discarded (nothing emitted).
  - Go to HEADER on an accepted `s_axis_tlast`.
- Counter width: SIZE − log2(STREAM_WIDTH/8) + 1 bits; no wrap (it is loaded before every use).
- `busy` = state≠HEADER or `m_axis_tvalid`.

## Timing
- Output stage is a one-entry pipeline register.
  - Latency is one cycle from the accepted input beat to `m_axis_tvalid`.
  - In LOAD, `s_axis_tready` = !`m_axis_tvalid` || `m_axis_tready`. Full throughput is one beat/cycle.
- `m_axis_tvalid` and `m_axis_tdata` hold stable while `m_axis_tready`=0.
- A header is never accepted while the output register still holds a beat of the previous packet's tlast. HEADER drives `s_axis_tready`=0 until that beat drains.
- Error flags update on the edge that accepts the triggering beat. They hold until the next header is accepted.
- Reset values:
  - state=HEADER, `s_axis_tready`=0 during reset then 1.
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0.
  - `mode`=4'b0000, `busy`=0, all error flags 0.
- Reset mid-packet aborts the packet immediately. No tlast is emitted, `mode` reverts to 0000, and the next accepted beat is treated as a header.

## Configuration
- `TEXTURE_LOADER_BYTESWAP_EN` defined: each 16-bit texel lane of the payload has its two bytes swapped before the output register. Header decode is unaffected.
- Undefined: payload passes bit-exact.

## Test plan
- STREAM_WIDTH=16, SIZE=14, header 0x0001, then 1024 beats with tlast on the last:
  - 1024 output beats, tlast only on beat 1024.
  - `mode`=0001 after the final handshake, no errors.
- Header 0x0002, 4096 beats, `m_axis_tready` toggling 50% randomly:
  - Data order is preserved, tlast on beat 4096, `mode`=0010.
- Header 0x0004 (32 KiB > 16 KiB):
  - `errMode`=1, the following 100 beats are dropped with zero output, `mode` is unchanged.
- Header 0x0001, tlast on beat 10:
  - 10 output beats with tlast on beat 10, `errShort`=1, `mode` stays at its old value.
- Header 0x0001, 1030 beats:
  - tlast on output beat 1024, `errLong`=1, beats 1025–1030 are dropped.
  - The next header clears `errLong`.
- `resetn` pulled low at beat 500 of a 64x64 upload:
  - All outputs return to reset values, `mode`=0000.
  - A fresh 32x32 packet then completes normally.
  - Repeat with `TEXTURE_LOADER_BYTESWAP_EN` defined: 0x1234 in → 0x3412 out.
